// File: rtl/channel_voice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : channel_voice_pkg
// Description : Shared definitions for the channel voice: envelope state
//               encodings, envelope ceiling and a sample-rendering helper.
// Revision    : 1.0 - initial release
// ============================================================================
package channel_voice_pkg;

    // Envelope state encodings
    localparam logic [1:0] ENV_IDLE    = 2'd0;
    localparam logic [1:0] ENV_ATTACK  = 2'd1;
    localparam logic [1:0] ENV_SUSTAIN = 2'd2;
    localparam logic [1:0] ENV_RELEASE = 2'd3;

    // Envelope ceiling
    localparam logic [3:0] LEVEL_MAX = 4'd15;

    // A 4-bit level is spread over the 8-bit sample range by repeating it in
    // both nibbles, so level 15 renders full scale (8'hff).
    function automatic logic [7:0] render_sample(input logic wave_high,
                                                 input logic [3:0] level);
        return wave_high ? {level, level} : 8'h00;
    endfunction

endpackage : channel_voice_pkg
`default_nettype wire

// File: rtl/channel_envelope.sv
`default_nettype none
// ============================================================================
// Module      : channel_envelope
// Description : Retriggerable linear attack/sustain/release volume envelope.
//               A trigger restarts the attack from level 0; a release moves
//               an active note into the release ramp. Level moves only on
//               envelope ticks, and note events take priority over ticks.
// Ports       : i_clk, i_rst (sync, active-high)
//               i_tick_stb  - envelope tick strobe
//               i_trigger   - start a new note (level 0, attack)
//               i_release   - end the current note
//               o_level     - 4-bit envelope level
//               o_note_on   - high while in attack or sustain
// Revision    : 1.0 - initial release
// ============================================================================
module channel_envelope
    import channel_voice_pkg::*;
#(
    parameter logic [3:0] ATTACK_STEP  = 4'd1,
    parameter logic [3:0] RELEASE_STEP = 4'd1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_stb,
    input  logic       i_trigger,
    input  logic       i_release,
    output logic [3:0] o_level,
    output logic       o_note_on
);

    logic [1:0] r_state;
    logic [3:0] r_level;
    logic       r_note_on;

    logic [1:0] w_state_next;
    logic [3:0] w_level_next;
    logic       w_note_on_next;
    logic [4:0] w_attack_sum;

    // One bit of headroom so the saturation test sees the true sum.
    assign w_attack_sum = {1'b0, r_level} + {1'b0, ATTACK_STEP};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ENV_IDLE;
            r_level   <= 4'd0;
            r_note_on <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_level   <= w_level_next;
            r_note_on <= w_note_on_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        if (i_trigger) begin
            w_state_next = ENV_ATTACK;
            w_level_next = 4'd0;
        end else if (i_release) begin
            // A rest only matters for a sounding note; the tick is dropped.
            if ((r_state == ENV_ATTACK) || (r_state == ENV_SUSTAIN)) begin
                w_state_next = ENV_RELEASE;
            end
        end else if (i_tick_stb) begin
            case (r_state)
                ENV_ATTACK: begin
                    if (w_attack_sum >= {1'b0, LEVEL_MAX}) begin
                        w_level_next = LEVEL_MAX;
                        w_state_next = ENV_SUSTAIN;
                    end else begin
                        w_level_next = w_attack_sum[3:0];
                    end
                end
                ENV_RELEASE: begin
                    if (r_level <= RELEASE_STEP) begin
                        w_level_next = 4'd0;
                        w_state_next = ENV_IDLE;
                    end else begin
                        w_level_next = r_level - RELEASE_STEP;
                    end
                end
                ENV_SUSTAIN: w_level_next = LEVEL_MAX;
                default:     w_level_next = 4'd0;
            endcase
        end
    end

    // Output logic: note_on is registered from the upcoming state so it
    // lines up exactly with the state register.
    always_comb begin
        w_note_on_next = (w_state_next == ENV_ATTACK) ||
                         (w_state_next == ENV_SUSTAIN);
    end

    assign o_level   = r_level;
    assign o_note_on = r_note_on;

endmodule : channel_envelope
`default_nettype wire

// File: rtl/channel_voice.sv
`default_nettype none
// ============================================================================
// Module      : channel_voice
// Description : Pulse-wave voice for one sequencer channel. Accumulates the
//               phase delta per sample strobe, compares the phase against a
//               duty threshold and scales the pulse by a retriggered linear
//               envelope. Note changes are detected from delta changes; a
//               delta of 0 is a rest.
// Ports       : i_clk, i_rst (sync, active-high)
//               i_sample_stb   - sample-rate strobe
//               i_tick_stb     - envelope tick strobe
//               i_phase_delta  - phase increment per sample (0 = rest)
//               i_top, i_top_valid - duty control and its qualifier
//               o_sample       - 8-bit unsigned sample
//               o_sample_valid - pulses the cycle after each sample strobe
//               o_note_on      - high while envelope is in attack/sustain
// Revision    : 1.0 - initial release
// ============================================================================
module channel_voice
    import channel_voice_pkg::*;
#(
    parameter logic [3:0] ATTACK_STEP  = 4'd1,
    parameter logic [3:0] RELEASE_STEP = 4'd1,
    parameter logic [7:0] INIT_TOP     = 8'hff
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sample_stb,
    input  logic        i_tick_stb,
    input  logic [31:0] i_phase_delta,
    input  logic [7:0]  i_top,
    input  logic        i_top_valid,
    output logic [7:0]  o_sample,
    output logic        o_sample_valid,
    output logic        o_note_on
);

    logic [31:0] r_phase;
    logic [31:0] r_delta_q;
    logic [7:0]  r_top_pend;
    logic [7:0]  r_top_act;
    logic        r_out_due;
    logic [7:0]  r_sample_hold;

    logic        w_new_note;
    logic        w_note_trigger;
    logic        w_note_release;
    logic        w_sample_step;
    logic [32:0] w_phase_sum;
    logic        w_wave_high;
    logic [3:0]  w_level;
    logic [7:0]  w_sample_now;

    assign w_new_note     = (i_phase_delta != r_delta_q);
    assign w_note_trigger = w_new_note && (i_phase_delta != 32'd0);
    assign w_note_release = w_new_note && (i_phase_delta == 32'd0);

    // A note change in the same cycle as a sample strobe suppresses the add.
    assign w_sample_step  = i_sample_stb && !w_new_note;
    assign w_phase_sum    = {1'b0, r_phase} + {1'b0, r_delta_q};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase       <= 32'd0;
            r_delta_q     <= 32'd0;
            r_top_pend    <= INIT_TOP;
            r_top_act     <= INIT_TOP;
            r_out_due     <= 1'b0;
            r_sample_hold <= 8'h00;
        end else begin
            if (w_new_note) begin
                r_delta_q <= i_phase_delta;
            end

            if (w_note_trigger) begin
                r_phase <= 32'd0;
            end else if (w_sample_step) begin
                r_phase <= w_phase_sum[31:0];
            end

            // Duty is only switched at a period boundary (phase wrap) or at
            // note start, so a pulse is never cut short mid-period.
            if (w_note_trigger || (w_sample_step && w_phase_sum[32])) begin
                r_top_act <= r_top_pend;
            end

            if (i_top_valid) begin
                r_top_pend <= i_top;
            end

            r_out_due <= i_sample_stb;

            if (r_out_due) begin
                r_sample_hold <= w_sample_now;
            end
        end
    end

    channel_envelope #(
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_env (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tick_stb (i_tick_stb),
        .i_trigger  (w_note_trigger),
        .i_release  (w_note_release),
        .o_level    (w_level),
        .o_note_on  (o_note_on)
    );

    // phase[31:24] <= top[7:1] is rewritten as 2*phase[31:24] <= top: the
    // left side is even, so the floor of top/2 falls out of the comparison.
    assign w_wave_high  = ({r_phase[31:24], 1'b0} <= {1'b0, r_top_act});
    assign w_sample_now = render_sample(w_wave_high, w_level);

    // In the cycle after a strobe the sample is formed from the freshly
    // updated phase, duty and level; afterwards the captured copy is held.
    assign o_sample       = r_out_due ? w_sample_now : r_sample_hold;
    assign o_sample_valid = r_out_due;

endmodule : channel_voice
`default_nettype wire
